composite_router: RTL

Packet router sitting directly downstream of the composite arbiter. It accepts one meta word per packet followed by that packet's data beats, terminated by `last`. It steers both to one of four output meta/data channel pairs, selected by the meta word's low two bits. Each output channel is registered, so downstream paths are timing-isolated from the arbiter.

---
 rtl/composite_router.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/composite_router.sv
// Packet router: one meta word per packet steers the packet's data beats to one
// of four registered output channels chosen by meta[1:0].
module composite_router #(
    parameter int META_W = 8,
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_meta_valid,
    output logic              io_in_meta_ready,
    input  logic [META_W-1:0] io_in_meta_bits,
    input  logic              io_in_data_valid,
    output logic              io_in_data_ready,
    input  logic              io_in_data_bits_last,
    input  logic [DATA_W-1:0] io_in_data_bits_data,
    input  logic [KEEP_W-1:0] io_in_data_bits_keep,
    output logic              io_out_meta0_valid,
    input  logic              io_out_meta0_ready,
    output logic [META_W-1:0] io_out_meta0_bits,
    output logic              io_out_meta1_valid,
    input  logic              io_out_meta1_ready,
    output logic [META_W-1:0] io_out_meta1_bits,
    output logic              io_out_meta2_valid,
    input  logic              io_out_meta2_ready,
    output logic [META_W-1:0] io_out_meta2_bits,
    output logic              io_out_meta3_valid,
    input  logic              io_out_meta3_ready,
    output logic [META_W-1:0] io_out_meta3_bits,
    output logic              io_out_data0_valid,
    input  logic              io_out_data0_ready,
    output logic              io_out_data0_bits_last,
    output logic [DATA_W-1:0] io_out_data0_bits_data,
    output logic [KEEP_W-1:0] io_out_data0_bits_keep,
    output logic              io_out_data1_valid,
    input  logic              io_out_data1_ready,
    output logic              io_out_data1_bits_last,
    output logic [DATA_W-1:0] io_out_data1_bits_data,
    output logic [KEEP_W-1:0] io_out_data1_bits_keep,
    output logic              io_out_data2_valid,
    input  logic              io_out_data2_ready,
    output logic              io_out_data2_bits_last,
    output logic [DATA_W-1:0] io_out_data2_bits_data,
    output logic [KEEP_W-1:0] io_out_data2_bits_keep,
    output logic              io_out_data3_valid,
    input  logic              io_out_data3_ready,
    output logic              io_out_data3_bits_last,
    output logic [DATA_W-1:0] io_out_data3_bits_data,
    output logic [KEEP_W-1:0] io_out_data3_bits_keep
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [1:0]        dest;
    logic              meta_pend;
    logic [META_W-1:0] meta_q;

    logic              buf_last [2];
    logic [DATA_W-1:0] buf_data [2];
    logic [KEEP_W-1:0] buf_keep [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;

    logic [3:0] meta_rdy_vec;
    logic [3:0] data_rdy_vec;
    logic [3:0] meta_vld_vec;
    logic [3:0] data_vld_vec;
    logic       meta_acc;
    logic       meta_take;
    logic       push;
    logic       pop;

    assign meta_rdy_vec = {io_out_meta3_ready, io_out_meta2_ready,
                           io_out_meta1_ready, io_out_meta0_ready};
    assign data_rdy_vec = {io_out_data3_ready, io_out_data2_ready,
                           io_out_data1_ready, io_out_data0_ready};

    // Next meta waits for an empty buffer so buffered beats never follow a new dest.
    assign io_in_meta_ready = (state == IDLE) && !meta_pend && (count == 2'd0);
    assign io_in_data_ready = (state == BUSY) && (count < 2'd2);

    assign meta_acc  = io_in_meta_valid && io_in_meta_ready;
    assign meta_take = meta_pend && meta_rdy_vec[dest];
    assign push      = io_in_data_valid && io_in_data_ready;
    assign pop       = (count != 2'd0) && data_rdy_vec[dest];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dest      <= 2'd0;
            meta_pend <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            case (state)
                IDLE: if (meta_acc) begin
                    state <= BUSY;
                    dest  <= io_in_meta_bits[1:0];
                end
                BUSY: if (push && io_in_data_bits_last) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (meta_acc)       meta_pend <= 1'b1;
            else if (meta_take) meta_pend <= 1'b0;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    // Payload registers carry no reset; validity is tracked by meta_pend and count.
    always_ff @(posedge clock) begin
        if (meta_acc) meta_q <= io_in_meta_bits;
        if (push) begin
            buf_last[wr_ptr] <= io_in_data_bits_last;
            buf_data[wr_ptr] <= io_in_data_bits_data;
            buf_keep[wr_ptr] <= io_in_data_bits_keep;
        end
    end

    assign meta_vld_vec = {4{meta_pend}} & (4'b0001 << dest);
    assign data_vld_vec = {4{count != 2'd0}} & (4'b0001 << dest);

    assign io_out_meta0_valid = meta_vld_vec[0];
    assign io_out_meta1_valid = meta_vld_vec[1];
    assign io_out_meta2_valid = meta_vld_vec[2];
    assign io_out_meta3_valid = meta_vld_vec[3];
    assign io_out_meta0_bits  = meta_q;
    assign io_out_meta1_bits  = meta_q;
    assign io_out_meta2_bits  = meta_q;
    assign io_out_meta3_bits  = meta_q;

    assign io_out_data0_valid     = data_vld_vec[0];
    assign io_out_data1_valid     = data_vld_vec[1];
    assign io_out_data2_valid     = data_vld_vec[2];
    assign io_out_data3_valid     = data_vld_vec[3];
    assign io_out_data0_bits_last = buf_last[rd_ptr];
    assign io_out_data1_bits_last = buf_last[rd_ptr];
    assign io_out_data2_bits_last = buf_last[rd_ptr];
    assign io_out_data3_bits_last = buf_last[rd_ptr];
    assign io_out_data0_bits_data = buf_data[rd_ptr];
    assign io_out_data1_bits_data = buf_data[rd_ptr];
    assign io_out_data2_bits_data = buf_data[rd_ptr];
    assign io_out_data3_bits_data = buf_data[rd_ptr];
    assign io_out_data0_bits_keep = buf_keep[rd_ptr];
    assign io_out_data1_bits_keep = buf_keep[rd_ptr];
    assign io_out_data2_bits_keep = buf_keep[rd_ptr];
    assign io_out_data3_bits_keep = buf_keep[rd_ptr];

endmodule
